// File: rtl/bmu_pkg.sv
// Shared types and constants for the parallel branch metric unit.
package bmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } bmu_state_e;

  localparam int MIN_M = 2;
  localparam int MIN_N = 2;

  // Signed metric width: a sum of MAX_N sign-extended soft bits cannot overflow it.
  function automatic int bm_w(input int soft_w, input int max_n);
    return soft_w + 1 + $clog2(max_n);
  endfunction

endpackage

// File: rtl/bmu_lane.sv
// One trellis lane: low- and high-path codeword bits for a single current state.
module bmu_lane #(
  parameter int SW    = 8,
  parameter int MAX_N = 8
) (
  input  logic [MAX_N*SW-1:0] lo_mask_i,
  input  logic [MAX_N-1:0]    tap_i,
  input  logic [SW-1:0]       state_x_i,
  output logic [MAX_N-1:0]    c_lo_o,
  output logic [MAX_N-1:0]    c_hi_o
);

  always_comb begin
    c_lo_o = '0;
    for (int j = 0; j < MAX_N; j++) begin
      c_lo_o[j] = ^(lo_mask_i[j*SW +: SW] & state_x_i);
    end
  end

  // The high path differs from the low path only by the input-tap bit.
  assign c_hi_o = c_lo_o ^ tap_i;

endmodule

// File: rtl/bmu_par.sv
// Parametrised branch metric unit: 2-stage pipeline, config latched once per frame.
// Optional puncturing input enabled by defining BMU_PUNCTURE_EN.
module bmu_par
  import bmu_pkg::*;
#(
  parameter  int MAX_K  = 9,
  parameter  int MAX_N  = 8,
  parameter  int SOFT_W = 4,
  parameter  int LANES  = 2,
  localparam int SW     = MAX_K - 1,
  localparam int BM_W   = bm_w(SOFT_W, MAX_N)
) (
  input  logic                    clk_i,
  input  logic                    rst_an_i,
  input  logic                    rst_sync_i,
  input  logic                    frame_start_i,
  input  logic [3:0]              mem_len_i,
  input  logic [3:0]              num_polys_i,
  input  logic [MAX_N*MAX_K-1:0]  polys_i,
  input  logic [MAX_N*SOFT_W-1:0] soft_data_i,
  input  logic [LANES*SW-1:0]     state_x_i,
  input  logic                    in_valid_i,
`ifdef BMU_PUNCTURE_EN
  input  logic [MAX_N-1:0]        punct_mask_i,
`endif
  output logic                    in_ready_o,
  output logic [LANES*BM_W-1:0]   bm_lo_o,
  output logic [LANES*BM_W-1:0]   bm_hi_o,
  output logic                    bm_valid_o,
  input  logic                    bm_ready_i,
  output logic                    cfg_err_o,
  output logic [1:0]              dbg_state_o
);

  // Handshake: a beat moves on a clock edge where valid and ready are both high;
  // valid never depends on ready, and an offered output beat stays stable until taken.

  bmu_state_e                 state_q, state_d;
  logic [MAX_N*SW-1:0]        lo_mask_q, lo_mask_d;
  logic [MAX_N-1:0]           tap_q, tap_d;
  logic [MAX_N-1:0]           act_q, act_d;
  logic                       cfg_err_q, cfg_err_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [LANES*MAX_N-1:0]     s1_clo_q, s1_clo_d;
  logic [LANES*MAX_N-1:0]     s1_chi_q, s1_chi_d;
  logic [MAX_N*SOFT_W-1:0]    s1_soft_q, s1_soft_d;
  logic [MAX_N-1:0]           s1_punct_q, s1_punct_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [LANES*BM_W-1:0]      bm_lo_q, bm_lo_d;
  logic [LANES*BM_W-1:0]      bm_hi_q, bm_hi_d;

  logic [LANES*MAX_N-1:0]     c_lo, c_hi;
  logic [LANES*BM_W-1:0]      sum_lo, sum_hi;
  logic [MAX_N-1:0]           punct_in, use_bit;
  logic [BM_W-1:0]            term;
  logic                       pipe_en, accept, cfg_legal;

`ifdef BMU_PUNCTURE_EN
  assign punct_in = punct_mask_i;
`else
  assign punct_in = '0;
`endif

  assign cfg_legal = (int'(mem_len_i) >= MIN_M) && (int'(mem_len_i) <= MAX_K - 1) &&
                     (int'(num_polys_i) >= MIN_N) && (int'(num_polys_i) <= MAX_N);

  // Whole pipeline advances in lock step whenever the output register can move.
  assign pipe_en    = !s2_valid_q || bm_ready_i;
  assign in_ready_o = (state_q == ST_RUN) && pipe_en;
  assign accept     = in_valid_i && in_ready_o;
  assign use_bit    = act_q & ~s1_punct_q;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    bmu_lane #(
      .SW    (SW),
      .MAX_N (MAX_N)
    ) u_lane (
      .lo_mask_i (lo_mask_q),
      .tap_i     (tap_q),
      .state_x_i (state_x_i[l*SW +: SW]),
      .c_lo_o    (c_lo[l*MAX_N +: MAX_N]),
      .c_hi_o    (c_hi[l*MAX_N +: MAX_N])
    );
  end

  // Stage 2 arithmetic: soft bit counts positive when the codeword bit is 1.
  always_comb begin
    sum_lo = '0;
    sum_hi = '0;
    term   = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int j = 0; j < MAX_N; j++) begin
        term = {{(BM_W-SOFT_W){s1_soft_q[j*SOFT_W+SOFT_W-1]}}, s1_soft_q[j*SOFT_W +: SOFT_W]};
        if (use_bit[j]) begin
          sum_lo[l*BM_W +: BM_W] = s1_clo_q[l*MAX_N+j] ? sum_lo[l*BM_W +: BM_W] + term
                                                      : sum_lo[l*BM_W +: BM_W] - term;
          sum_hi[l*BM_W +: BM_W] = s1_chi_q[l*MAX_N+j] ? sum_hi[l*BM_W +: BM_W] + term
                                                      : sum_hi[l*BM_W +: BM_W] - term;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_err_d  = cfg_err_q;
    lo_mask_d  = lo_mask_q;
    tap_d      = tap_q;
    act_d      = act_q;
    s1_valid_d = s1_valid_q;
    s1_clo_d   = s1_clo_q;
    s1_chi_d   = s1_chi_q;
    s1_soft_d  = s1_soft_q;
    s1_punct_d = s1_punct_q;
    s2_valid_d = s2_valid_q;
    bm_lo_d    = bm_lo_q;
    bm_hi_d    = bm_hi_q;

    if (state_q == ST_CFG) begin
      lo_mask_d = '0;
      tap_d     = '0;
      act_d     = '0;
      for (int j = 0; j < MAX_N; j++) begin
        act_d[j] = (j < int'(num_polys_i));
        for (int b = 0; b < SW; b++) begin
          lo_mask_d[j*SW+b] = act_d[j] && polys_i[j*MAX_K+b] && (b < int'(mem_len_i));
        end
        for (int b = 0; b < MAX_K; b++) begin
          if (b == int'(mem_len_i)) tap_d[j] = act_d[j] && polys_i[j*MAX_K+b];
        end
      end
    end

    if (frame_start_i) begin
      state_d   = ST_CFG;
      cfg_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_CFG: begin
          if (cfg_legal) begin
            state_d = ST_RUN;
          end else begin
            state_d   = ST_ERR;
            cfg_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A new frame discards anything still in flight.
    if (frame_start_i) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (pipe_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        bm_lo_d = sum_lo;
        bm_hi_d = sum_hi;
      end
      s1_valid_d = accept;
      if (accept) begin
        s1_clo_d   = c_lo;
        s1_chi_d   = c_hi;
        s1_soft_d  = soft_data_i;
        s1_punct_d = punct_in;
      end
    end

    if (rst_sync_i) begin
      state_d    = ST_IDLE;
      cfg_err_d  = 1'b0;
      lo_mask_d  = '0;
      tap_d      = '0;
      act_d      = '0;
      s1_valid_d = 1'b0;
      s1_clo_d   = '0;
      s1_chi_d   = '0;
      s1_soft_d  = '0;
      s1_punct_d = '0;
      s2_valid_d = 1'b0;
      bm_lo_d    = '0;
      bm_hi_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q    <= ST_IDLE;
      cfg_err_q  <= 1'b0;
      lo_mask_q  <= '0;
      tap_q      <= '0;
      act_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_clo_q   <= '0;
      s1_chi_q   <= '0;
      s1_soft_q  <= '0;
      s1_punct_q <= '0;
      s2_valid_q <= 1'b0;
      bm_lo_q    <= '0;
      bm_hi_q    <= '0;
    end else begin
      state_q    <= state_d;
      cfg_err_q  <= cfg_err_d;
      lo_mask_q  <= lo_mask_d;
      tap_q      <= tap_d;
      act_q      <= act_d;
      s1_valid_q <= s1_valid_d;
      s1_clo_q   <= s1_clo_d;
      s1_chi_q   <= s1_chi_d;
      s1_soft_q  <= s1_soft_d;
      s1_punct_q <= s1_punct_d;
      s2_valid_q <= s2_valid_d;
      bm_lo_q    <= bm_lo_d;
      bm_hi_q    <= bm_hi_d;
    end
  end

  assign bm_lo_o     = bm_lo_q;
  assign bm_hi_o     = bm_hi_q;
  assign bm_valid_o  = s2_valid_q;
  assign cfg_err_o   = cfg_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bmu_par.sv
// Directed bench for bmu_par: K=7 (M=6), N=2, polys 0o171/0o133, two lanes.
module tb_bmu_par;

  localparam int MAX_K  = 9;
  localparam int MAX_N  = 8;
  localparam int SOFT_W = 4;
  localparam int LANES  = 2;
  localparam int SW     = 8;
  localparam int BM_W   = 8;
  localparam int OW     = 2*LANES*BM_W;

  logic                    clk = 1'b0;
  logic                    rst_an_i, rst_sync_i, frame_start_i;
  logic [3:0]              mem_len_i, num_polys_i;
  logic [MAX_N*MAX_K-1:0]  polys_i;
  logic [MAX_N*SOFT_W-1:0] soft_data_i;
  logic [LANES*SW-1:0]     state_x_i;
  logic                    in_valid_i, in_ready_o;
  logic [LANES*BM_W-1:0]   bm_lo_o, bm_hi_o;
  logic                    bm_valid_o, bm_ready_i, cfg_err_o;
  logic [1:0]              dbg_state_o;
`ifdef BMU_PUNCTURE_EN
  logic [MAX_N-1:0]        punct_mask;
`endif

  typedef struct {
    logic [SW-1:0]     x0, x1;
    logic [SOFT_W-1:0] s0, s1;
    logic [BM_W-1:0]   lo0, hi0, lo1, hi1;
  } vec_t;

  vec_t          vecs[5];
  logic [OW-1:0] exp_q[$];
  int            tests = 0;
  int            fails = 0;

  bmu_par u_dut (
    .clk_i         (clk),
    .rst_an_i      (rst_an_i),
    .rst_sync_i    (rst_sync_i),
    .frame_start_i (frame_start_i),
    .mem_len_i     (mem_len_i),
    .num_polys_i   (num_polys_i),
    .polys_i       (polys_i),
    .soft_data_i   (soft_data_i),
    .state_x_i     (state_x_i),
    .in_valid_i    (in_valid_i),
`ifdef BMU_PUNCTURE_EN
    .punct_mask_i  (punct_mask),
`endif
    .in_ready_o    (in_ready_o),
    .bm_lo_o       (bm_lo_o),
    .bm_hi_o       (bm_hi_o),
    .bm_valid_o    (bm_valid_o),
    .bm_ready_i    (bm_ready_i),
    .cfg_err_o     (cfg_err_o),
    .dbg_state_o   (dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not end, got timeout, required finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- helpers ----------------
  function automatic logic [BM_W-1:0] bm(input int v);
    return v[BM_W-1:0];
  endfunction

  function automatic logic [SOFT_W-1:0] sb(input int v);
    return v[SOFT_W-1:0];
  endfunction

  function automatic vec_t mk(input logic [SW-1:0] x0, input logic [SW-1:0] x1,
                              input int s0, input int s1,
                              input int lo0, input int hi0, input int lo1, input int hi1);
    vec_t v;
    v.x0 = x0;       v.x1 = x1;
    v.s0 = sb(s0);   v.s1 = sb(s1);
    v.lo0 = bm(lo0); v.hi0 = bm(hi0);
    v.lo1 = bm(lo1); v.hi1 = bm(hi1);
    return v;
  endfunction

  function automatic logic [OW-1:0] pack_exp(input vec_t v);
    return {v.hi1, v.hi0, v.lo1, v.lo0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Poly bits above the input tap are set on purpose; they must not reach the masks.
  task automatic set_polys();
    for (int j = 0; j < MAX_N; j++) polys_i[j*MAX_K +: MAX_K] = 9'h1FF;
    polys_i[0*MAX_K +: MAX_K] = 9'h1F9;
    polys_i[1*MAX_K +: MAX_K] = 9'h1DB;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_vec(input vec_t v);
    state_x_i   = {v.x1, v.x0};
    soft_data_i = {24'h777777, v.s1, v.s0};
  endtask

  task automatic send_vec(input vec_t v);
    int n;
    n = 0;
    drive_vec(v);
    in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got in_ready_o=0 for 50 cycles, required 1");
    end else begin
      exp_q.push_back(pack_exp(v));
    end
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic do_frame();
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    tick();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_an_i && !rst_sync_i && bm_valid_o && bm_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %0h, required no beat", {bm_hi_o, bm_lo_o});
      end else begin
        check("beat", 64'({bm_hi_o, bm_lo_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst_an_i = 1'b0; rst_sync_i = 1'b0; frame_start_i = 1'b0;
    mem_len_i = 4'd6; num_polys_i = 4'd2; set_polys();
    soft_data_i = '0; state_x_i = '0; in_valid_i = 1'b0; bm_ready_i = 1'b1;
`ifdef BMU_PUNCTURE_EN
    punct_mask = '0;
`endif

    //           x0     x1     s0  s1  lo0  hi0  lo1  hi1
    vecs[0] = mk(8'h00, 8'h01,  3,  5,  -8,   8,   8,  -8);
    vecs[1] = mk(8'h3F, 8'h02, -8, -8,  16, -16,   0,   0);
    vecs[2] = mk(8'h08, 8'h20, -1,  7,   6,  -6,  -8,   8);
    vecs[3] = mk(8'hC0, 8'h07,  4, -3,  -1,   1,   7,  -7);
    vecs[4] = mk(8'h3F, 8'h30,  7, -8,   1,  -1, -15,  15);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",  64'(bm_valid_o), 64'(0));
    check("rst_lo",     64'(bm_lo_o), 64'(0));
    check("rst_hi",     64'(bm_hi_o), 64'(0));
    check("rst_ready",  64'(in_ready_o), 64'(0));
    check("rst_cfgerr", 64'(cfg_err_o), 64'(0));
    check("rst_state",  64'(dbg_state_o), 64'(0));
    tick();
    rst_an_i   = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(in_ready_o), 64'(0));
    tick();
    in_valid_i = 1'b0;

    do_frame();
    @(negedge clk);
    check("run_state",  64'(dbg_state_o), 64'(2));
    check("run_ready",  64'(in_ready_o), 64'(1));
    check("run_cfgerr", 64'(cfg_err_o), 64'(0));
    tick();

    // table vectors, back to back
    for (int i = 0; i < 5; i++) send_vec(vecs[i]);
    drain();

    // latency with an idle pipeline
    send_vec(vecs[1]);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bm_valid_o && n < 10);
    check("latency", 64'(n), 64'(2));
    tick();
    drain();

    // backpressure: 3 beats, downstream stalled for 5 cycles
    fork
      begin
        send_vec(vecs[0]);
        send_vec(vecs[1]);
        send_vec(vecs[2]);
      end
      begin
        bm_ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) begin
          @(negedge clk);
          if (i >= 3) begin
            check("bp_ready_low", 64'(in_ready_o), 64'(0));
            check("bp_valid",     64'(bm_valid_o), 64'(1));
            check("bp_hold",      64'({bm_hi_o, bm_lo_o}), 64'(pack_exp(vecs[0])));
          end
        end
        tick();
        bm_ready_i = 1'b1;
      end
    join
    drain();

    // frame_start with two beats in flight
    drive_vec(vecs[2]);
    in_valid_i = 1'b1;
    @(negedge clk);
    check("flush_acc1", 64'(in_ready_o), 64'(1));
    tick();
    drive_vec(vecs[3]);
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    in_valid_i    = 1'b0;
    @(negedge clk);
    check("flush_cfg_state", 64'(dbg_state_o), 64'(1));
    check("flush_cfg_ready", 64'(in_ready_o), 64'(0));
    check("flush_cfg_valid", 64'(bm_valid_o), 64'(0));
    tick();
    @(negedge clk);
    check("flush_ready_2cyc", 64'(in_ready_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      check("flush_no_valid", 64'(bm_valid_o), 64'(0));
      @(negedge clk);
    end
    tick();

    // config inputs are ignored mid-frame
    polys_i = '0; num_polys_i = 4'd8; mem_len_i = 4'd3;
    send_vec(vecs[0]);
    send_vec(vecs[4]);
    drain();
    mem_len_i = 4'd6; num_polys_i = 4'd2; set_polys();

    // illegal N, then recovery
    num_polys_i = 4'd9;
    do_frame();
    in_valid_i = 1'b1;
    @(negedge clk);
    check("errn_cfgerr", 64'(cfg_err_o), 64'(1));
    check("errn_ready",  64'(in_ready_o), 64'(0));
    check("errn_state",  64'(dbg_state_o), 64'(3));
    tick();
    @(negedge clk);
    check("errn_ready_hold", 64'(in_ready_o), 64'(0));
    tick();
    in_valid_i    = 1'b0;
    num_polys_i   = 4'd2;
    frame_start_i = 1'b1;
    tick();
    frame_start_i = 1'b0;
    @(negedge clk);
    check("errn_cleared", 64'(cfg_err_o), 64'(0));
    tick();
    @(negedge clk);
    check("errn_recover_ready", 64'(in_ready_o), 64'(1));
    tick();

    // illegal M at both ends of the range
    mem_len_i = 4'd1;
    do_frame();
    @(negedge clk);
    check("errm_low", 64'(cfg_err_o), 64'(1));
    tick();
    mem_len_i = 4'd9;
    do_frame();
    @(negedge clk);
    check("errm_high", 64'(cfg_err_o), 64'(1));
    tick();
    mem_len_i = 4'd6;
    do_frame();
    @(negedge clk);
    check("errm_recover", 64'(cfg_err_o), 64'(0));
    tick();
    send_vec(vecs[3]);
    drain();

`ifdef BMU_PUNCTURE_EN
    // puncture soft bit 1; the mask travels with its beat
    punct_mask = 8'b0000_0010;
    send_vec(mk(8'h00, 8'h01, 3, 5, -3, 3, 3, -3));
    punct_mask = '0;
    send_vec(vecs[0]);
    drain();
`endif

    // synchronous reset clears the sticky error and outputs
    num_polys_i = 4'd9;
    do_frame();
    @(negedge clk);
    check("sync_pre_cfgerr", 64'(cfg_err_o), 64'(1));
    tick();
    rst_sync_i = 1'b1;
    tick();
    rst_sync_i  = 1'b0;
    num_polys_i = 4'd2;
    @(negedge clk);
    check("sync_state",  64'(dbg_state_o), 64'(0));
    check("sync_cfgerr", 64'(cfg_err_o), 64'(0));
    check("sync_lo",     64'(bm_lo_o), 64'(0));
    check("sync_hi",     64'(bm_hi_o), 64'(0));
    check("sync_valid",  64'(bm_valid_o), 64'(0));
    check("sync_ready",  64'(in_ready_o), 64'(0));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
